fetch_prefetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the datapath decode stage. Issues sequential

---
 rtl/fetch_prefetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers returned
// {pc, instr} pairs in an in-order queue and flushes/restarts on redirect.
module fetch_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0]  pc_mem_q   [DEPTH];
   logic [XLEN-1:0]  data_mem_q [DEPTH];

   logic [CNT_W-1:0] live_s;
   logic [31:0]      reserved_s;
   logic [XLEN-1:0]  redirect_pc_s;
   logic             req_valid_s;
   logic             req_fire_s;
   logic             rsp_ok_s;
   logic             rsp_drop_s;
   logic             push_s;
   logic             pop_s;
   logic             inst_valid_s;

   // Handshake qualification; a request reserves a queue slot for its response.
   always_comb begin
      redirect_pc_s = redirect_pc & ~XLEN'(2'b11);
      live_s        = inflight_q - drop_q;
      reserved_s    = 32'(occ_q) + 32'(live_s);
      req_valid_s   = !reset && !redirect_valid &&
                      (32'(inflight_q) < 32'(MAX_OUT)) &&
                      (reserved_s < 32'(DEPTH));
      req_fire_s    = req_valid_s && imem_req_ready;
      rsp_ok_s      = imem_rsp_valid && (inflight_q != {CNT_W{1'b0}});
      rsp_drop_s    = rsp_ok_s && (drop_q != {CNT_W{1'b0}});
      push_s        = rsp_ok_s && (drop_q == {CNT_W{1'b0}}) && !redirect_valid;
      inst_valid_s  = !reset && !redirect_valid && (occ_q != {OCC_W{1'b0}});
      pop_s         = inst_valid_s && inst_ready;
   end

   // Next-state for fetch/response pointers, in-flight accounting and queue pointers.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      occ_d      = occ_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (redirect_valid) begin
         // every request still outstanding after this cycle belongs to the old path
         fetch_pc_d = redirect_pc_s;
         rsp_pc_d   = redirect_pc_s;
         inflight_d = inflight_q - CNT_W'(rsp_ok_s);
         drop_d     = inflight_q - CNT_W'(rsp_ok_s);
         occ_d      = {OCC_W{1'b0}};
         wr_ptr_d   = {PTR_W{1'b0}};
         rd_ptr_d   = {PTR_W{1'b0}};
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + XLEN'(3'd4);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (push_s) begin
            rsp_pc_d = rsp_pc_q + XLEN'(3'd4);
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
         end else begin
            rsp_pc_d = rsp_pc_q;
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         inflight_d = inflight_q + CNT_W'(req_fire_s) - CNT_W'(rsp_ok_s);
         drop_d     = drop_q - CNT_W'(rsp_drop_s);
         occ_d      = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= {CNT_W{1'b0}};
         drop_q     <= {CNT_W{1'b0}};
         occ_q      <= {OCC_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Queue storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clock) begin
      if (push_s) begin
         pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
         data_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_q;
   assign inst_valid     = inst_valid_s;
   assign inst_pc        = pc_mem_q[rd_ptr_q];
   assign inst_data      = data_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a latency-programmable instruction memory
// model, a table of per-cycle vectors and hand-written redirect/reset/wrap sequences.
module tb_fetch_prefetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;

   always #5 clock = ~clock;

   fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUT(4), .RESET_PC(32'h0)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        rst;
      logic        ir;
      logic        chk;
      logic        rv;
      logic [31:0] ra;
      logic        iv;
      logic [31:0] pc;
   } vec_t;

   pend_t pend[$];
   vec_t  vecs[$];
   int    cyc    = 0;
   int    lat    = 1;
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at the negative edge: records the request handshake, advances one
   // clock and drives the memory response for the following cycle.
   task automatic tick();
      logic        fire;
      logic [31:0] fa;
      fire = imem_req_valid && imem_req_ready;
      fa   = imem_req_addr;
      @(posedge clock);
      #1;
      cyc++;
      if (fire) pend.push_back('{fa, cyc - 1 + lat});
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic exp_cycle(input string name, input logic rv, input logic [31:0] ra,
                            input logic iv, input logic [31:0] pc);
      @(negedge clock);
      check({name, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
      if (rv) check({name, "_req_addr"}, imem_req_addr, ra);
      check({name, "_inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
      if (iv) begin
         check({name, "_inst_pc"}, inst_pc, pc);
         check({name, "_inst_data"}, inst_data, mem_word(pc));
      end
      tick();
   endtask

   task automatic idle_cycle();
      @(negedge clock);
      tick();
   endtask

   task automatic do_reset();
      int guard;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      repeat (2) idle_cycle();
      guard = 0;
      while (pend.size() != 0 && guard < 50) begin
         idle_cycle();
         guard++;
      end
      idle_cycle();
      reset = 1'b0;
   endtask

   task automatic add(input logic rst, input logic ir, input logic chk, input logic rv,
                      input logic [31:0] ra, input logic iv, input logic [31:0] pc);
      vecs.push_back('{rst, ir, chk, rv, ra, iv, pc});
   endtask

   initial begin
      int pops;
      logic [31:0] exp_pc;

      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b1;

      // streaming after a two-cycle reset, one instruction per cycle
      add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8);
      // consumer stalled for ten cycles: queue fills to four, fetch stops
      add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h0);
      for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);

      foreach (vecs[i]) begin
         reset      = vecs[i].rst;
         inst_ready = vecs[i].ir;
         @(negedge clock);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].rv});
            if (vecs[i].rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].ra);
            check($sformatf("vec%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].iv});
            if (vecs[i].iv) begin
               check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].pc);
               check($sformatf("vec%0d_inst_data", i), inst_data, mem_word(vecs[i].pc));
            end
         end
         tick();
      end

      // redirect with three requests in flight and one entry queued
      do_reset();
      lat        = 3;
      inst_ready = 1'b0;
      exp_cycle("rd_c0", 1'b1, 32'h0, 1'b0, 32'h0);
      exp_cycle("rd_c1", 1'b1, 32'h4, 1'b0, 32'h0);
      exp_cycle("rd_c2", 1'b1, 32'h8, 1'b0, 32'h0);
      exp_cycle("rd_c3", 1'b1, 32'hC, 1'b0, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      exp_cycle("rd_c4", 1'b0, 32'h0, 1'b0, 32'h0);
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      exp_cycle("rd_c5", 1'b1, 32'h100, 1'b0, 32'h0);
      exp_cycle("rd_c6", 1'b1, 32'h104, 1'b0, 32'h0);
      exp_cycle("rd_c7", 1'b1, 32'h108, 1'b0, 32'h0);
      exp_cycle("rd_c8", 1'b1, 32'h10C, 1'b0, 32'h0);
      exp_cycle("rd_c9", 1'b0, 32'h0,   1'b1, 32'h100);
      exp_cycle("rd_c10", 1'b1, 32'h110, 1'b1, 32'h104);

      // reset mid-stream with two requests in flight; late responses must be ignored
      do_reset();
      lat = 3;
      exp_cycle("rs_c0", 1'b1, 32'h0, 1'b0, 32'h0);
      exp_cycle("rs_c1", 1'b1, 32'h4, 1'b0, 32'h0);
      reset = 1'b1;
      exp_cycle("rs_c2", 1'b0, 32'h0, 1'b0, 32'h0);
      reset          = 1'b0;
      imem_req_ready = 1'b0;
      exp_cycle("rs_c3", 1'b1, 32'h0, 1'b0, 32'h0);
      exp_cycle("rs_c4", 1'b1, 32'h0, 1'b0, 32'h0);
      imem_req_ready = 1'b1;
      exp_cycle("rs_c5", 1'b1, 32'h0, 1'b0, 32'h0);
      exp_cycle("rs_c6", 1'b1, 32'h4, 1'b0, 32'h0);
      exp_cycle("rs_c7", 1'b1, 32'h8, 1'b0, 32'h0);
      exp_cycle("rs_c8", 1'b1, 32'hC, 1'b0, 32'h0);
      exp_cycle("rs_c9", 1'b0, 32'h0, 1'b1, 32'h0);

      // fetch address wraps past the top of the address space
      do_reset();
      lat            = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      exp_cycle("wr_c0", 1'b0, 32'h0, 1'b0, 32'h0);
      redirect_valid = 1'b0;
      exp_cycle("wr_c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      exp_cycle("wr_c2", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
      exp_cycle("wr_c3", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
      exp_cycle("wr_c4", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);

      // irregular consumer and memory back-pressure: strict order, no loss
      do_reset();
      lat    = 2;
      exp_pc = 32'h0;
      pops   = 0;
      for (int i = 0; i < 60; i++) begin
         inst_ready     = (i < 8) ? 1'b0 : ((i % 5) != 1);
         imem_req_ready = ((i % 3) != 2);
         @(negedge clock);
         if (inst_valid && inst_ready) begin
            check("stream_pc", inst_pc, exp_pc);
            check("stream_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         tick();
      end
      check("stream_pop_count_min", {31'd0, pops >= 20}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
